// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: registered N-to-1 selector with per-channel valid/ready
// handshake and built-in fixed-priority (MODE 0) or round-robin (MODE 1)
// arbitration. Sustains one transfer per cycle.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active-low
//   data_i   CH packed channel words, channel k at [k*SIZE +: SIZE]
//   valid_i  per-channel request
//   ready_o  one-hot grant (or zero) to the winning channel
//   data_o   registered selected word
//   sel_o    index of the channel held in data_o
//   valid_o  data_o/sel_o hold a valid entry
//   ready_i  downstream accepts data_o this cycle
module mux_arb_nto1 #(
    parameter  int SIZE = 32,
    parameter  int CH   = 2,
    parameter  int MODE = 1,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CH*SIZE-1:0] data_i,
    input  logic [CH-1:0]      valid_i,
    output logic [CH-1:0]      ready_o,
    output logic [SIZE-1:0]    data_o,
    output logic [CW-1:0]      sel_o,
    output logic               valid_o,
    input  logic               ready_i
);

    // Index of the channel granted most recently (round-robin only).
    logic [CW-1:0]   rr_ptr;

    logic            load_ok;
    logic            any_req;
    logic            accept;
    logic [CH-1:0]   hi_req;
    logic [CW-1:0]   win;
    logic [SIZE-1:0] win_data;

    // Lowest set bit of a request vector.
    function automatic logic [CW-1:0] first_set(input logic [CH-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = CW'(k);
            end
        end
        return r;
    endfunction

    // The output register can take a new word when empty or when it is
    // being drained in the same cycle.
    assign load_ok = !valid_o || ready_i;
    assign any_req = |valid_i;
    assign accept  = rst_i && load_ok && any_req;

    // Requests strictly above the last grant; if any exist the rotated
    // search finds its winner there, otherwise it wraps to the bottom.
    always_comb begin
        hi_req = '0;
        for (int k = 0; k < CH; k++) begin
            hi_req[k] = valid_i[k] && (CW'(k) > rr_ptr);
        end
    end

    always_comb begin
        win = '0;
        if (MODE == 1 && |hi_req) begin
            win = first_set(hi_req);
        end else begin
            win = first_set(valid_i);
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (win == CW'(k)) begin
                win_data = data_i[k*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        ready_o = '0;
        for (int k = 0; k < CH; k++) begin
            ready_o[k] = accept && (win == CW'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sel_o   <= '0;
            rr_ptr  <= CW'(CH - 1);
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= win_data;
            sel_o   <= win;
            if (MODE == 1) begin
                rr_ptr <= win;
            end
        end else if (ready_i) begin
            // Drained with nothing to refill: entry retires, data holds.
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: four configurations driven by random
// handshaking sources and compared against a behavioural model.
module tb_mux_arb_nto1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int nch  [4] = '{2, 4, 3, 1};
    int mode [4] = '{1, 0, 1, 0};
    int sz   [4] = '{32, 8, 16, 8};

    bit          s_vld [4][4];
    logic [31:0] s_dat [4][4];
    bit          s_rdy [4];

    bit          m_vo  [4];
    logic [31:0] m_dat [4];
    int          m_sel [4];
    int          m_rr  [4];
    logic [3:0]  m_rdy [4];

    int n_pass = 0;
    int n_chk  = 0;

    // instance A: CH=2 MODE=1 SIZE=32
    logic [63:0] a_data;
    logic [1:0]  a_valid, a_ready;
    logic [31:0] a_q;
    logic        a_sel, a_vo;
    // instance B: CH=4 MODE=0 SIZE=8
    logic [31:0] b_data;
    logic [3:0]  b_valid, b_ready;
    logic [7:0]  b_q;
    logic [1:0]  b_sel;
    logic        b_vo;
    // instance C: CH=3 MODE=1 SIZE=16
    logic [47:0] c_data;
    logic [2:0]  c_valid, c_ready;
    logic [15:0] c_q;
    logic [1:0]  c_sel;
    logic        c_vo;
    // instance D: CH=1 MODE=0 SIZE=8
    logic [7:0]  d_data;
    logic        d_valid, d_ready;
    logic [7:0]  d_q;
    logic        d_sel, d_vo;

    assign a_data  = {s_dat[0][1], s_dat[0][0]};
    assign a_valid = {s_vld[0][1], s_vld[0][0]};
    assign b_data  = {s_dat[1][3][7:0], s_dat[1][2][7:0],
                      s_dat[1][1][7:0], s_dat[1][0][7:0]};
    assign b_valid = {s_vld[1][3], s_vld[1][2], s_vld[1][1], s_vld[1][0]};
    assign c_data  = {s_dat[2][2][15:0], s_dat[2][1][15:0],
                      s_dat[2][0][15:0]};
    assign c_valid = {s_vld[2][2], s_vld[2][1], s_vld[2][0]};
    assign d_data  = s_dat[3][0][7:0];
    assign d_valid = s_vld[3][0];

    mux_arb_nto1 #(.SIZE(32), .CH(2), .MODE(1)) u_a (
        .clk_i(clk), .rst_i(rst_n), .data_i(a_data), .valid_i(a_valid),
        .ready_o(a_ready), .data_o(a_q), .sel_o(a_sel), .valid_o(a_vo),
        .ready_i(s_rdy[0]));
    mux_arb_nto1 #(.SIZE(8), .CH(4), .MODE(0)) u_b (
        .clk_i(clk), .rst_i(rst_n), .data_i(b_data), .valid_i(b_valid),
        .ready_o(b_ready), .data_o(b_q), .sel_o(b_sel), .valid_o(b_vo),
        .ready_i(s_rdy[1]));
    mux_arb_nto1 #(.SIZE(16), .CH(3), .MODE(1)) u_c (
        .clk_i(clk), .rst_i(rst_n), .data_i(c_data), .valid_i(c_valid),
        .ready_o(c_ready), .data_o(c_q), .sel_o(c_sel), .valid_o(c_vo),
        .ready_i(s_rdy[2]));
    mux_arb_nto1 #(.SIZE(8), .CH(1), .MODE(0)) u_d (
        .clk_i(clk), .rst_i(rst_n), .data_i(d_data), .valid_i(d_valid),
        .ready_o(d_ready), .data_o(d_q), .sel_o(d_sel), .valid_o(d_vo),
        .ready_i(s_rdy[3]));

    logic [3:0]  o_rdy [4];
    logic [31:0] o_dat [4];
    logic [1:0]  o_sel [4];
    logic        o_vo  [4];

    assign o_rdy[0] = {2'b00, a_ready};
    assign o_rdy[1] = b_ready;
    assign o_rdy[2] = {1'b0, c_ready};
    assign o_rdy[3] = {3'b000, d_ready};
    assign o_dat[0] = a_q;
    assign o_dat[1] = {24'd0, b_q};
    assign o_dat[2] = {16'd0, c_q};
    assign o_dat[3] = {24'd0, d_q};
    assign o_sel[0] = {1'b0, a_sel};
    assign o_sel[1] = b_sel;
    assign o_sel[2] = c_sel;
    assign o_sel[3] = {1'b0, d_sel};
    assign o_vo[0]  = a_vo;
    assign o_vo[1]  = b_vo;
    assign o_vo[2]  = c_vo;
    assign o_vo[3]  = d_vo;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mask(int j);
        if (sz[j] >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << sz[j]) - 32'h1;
    endfunction

    // Search order from the rules: lowest index, or rotated from rr+1.
    function automatic int winner(int j);
        int k;
        for (int i = 1; i <= nch[j]; i++) begin
            k = (mode[j] == 1) ? (m_rr[j] + i) % nch[j] : i - 1;
            if (s_vld[j][k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_vo[j]  = 1'b0;
            m_dat[j] = '0;
            m_sel[j] = 0;
            m_rr[j]  = nch[j] - 1;
            m_rdy[j] = '0;
        end
    endtask

    task automatic compute_ready();
        int w;
        bit load;
        for (int j = 0; j < 4; j++) begin
            w = winner(j);
            load = !m_vo[j] || s_rdy[j];
            m_rdy[j] = (rst_n && load && w >= 0) ? 4'(1 << w) : 4'd0;
        end
    endtask

    task automatic advance();
        int w;
        for (int j = 0; j < 4; j++) begin
            w = winner(j);
            if (m_rdy[j] != 0) begin
                m_vo[j]  = 1'b1;
                m_dat[j] = s_dat[j][w];
                m_sel[j] = w;
                if (mode[j] == 1) m_rr[j] = w;
            end else if (s_rdy[j]) begin
                m_vo[j] = 1'b0;
            end
        end
    endtask

    // Sources hold valid/data until granted, then draw a new request.
    task automatic drive(int pv, int pr);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < nch[j]; k++) begin
                if (!s_vld[j][k] || m_rdy[j][k]) begin
                    s_vld[j][k] = ($urandom_range(99) < pv);
                    s_dat[j][k] = $urandom & mask(j);
                end
            end
            s_rdy[j] = ($urandom_range(99) < pr);
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ready_o[%0d]", j), 32'(o_rdy[j]), 32'(m_rdy[j]));
            chk($sformatf("valid_o[%0d]", j), 32'(o_vo[j]), 32'(m_vo[j]));
            chk($sformatf("data_o[%0d]", j), o_dat[j], m_dat[j]);
            chk($sformatf("sel_o[%0d]", j), 32'(o_sel[j]), 32'(m_sel[j]));
        end
    endtask

    task automatic run(int n, int pv, int pr);
        repeat (n) begin
            @(negedge clk);
            drive(pv, pr);
            #1;
            compute_ready();
            check_all();
            advance();
        end
    endtask

    // Reset asserted between edges while entries are held.
    task automatic reset_mid();
        @(negedge clk);
        drive(100, 0);
        #1;
        compute_ready();
        check_all();
        for (int j = 0; j < 4; j++) chk("held_before_rst", 32'(o_vo[j]), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compute_ready();
        check_all();
        #2 rst_n = 1'b1;
        #1;
        compute_ready();
        check_all();
        for (int j = 0; j < 4; j++) chk("first_grant_ch0", 32'(o_rdy[j]), 1);
        advance();
    endtask

    initial begin
        for (int j = 0; j < 4; j++) begin
            s_rdy[j] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                s_vld[j][k] = 1'b0;
                s_dat[j][k] = '0;
            end
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        compute_ready();
        check_all();
        #1 rst_n = 1'b1;
        run(80, 60, 70);
        run(30, 100, 100);
        run(10, 100, 0);
        run(20, 70, 50);
        run(15, 0, 100);
        run(10, 100, 100);
        reset_mid();
        run(300, 50, 50);
        run(40, 100, 100);
        run(100, 80, 30);
        reset_mid();
        run(100, 40, 80);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
